bus_mm_rr: RTL

//  Parametrised shared bus with N masters, M slaves and a registered round-robin arbiter.

---
 rtl/bus_pkg.sv | 38 +++
 rtl/bus_rr_arbiter.sv | 79 +++++++
 rtl/bus_mm_rr.sv | 98 +++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types, constants and helpers for the multi-master round-robin bus.
// Address page = addr >> PAGE_LSB; page j+1 maps to slave j.
package bus_pkg;

    typedef enum logic {IDLE, BUSY} state_e;

    localparam int PAGE_LSB = 8;
    localparam int MAX_S    = 15;
    localparam int OH_W     = MAX_S + 1;
    localparam int ADDR_MAX = 64;

    typedef struct packed {
        logic       vld;
        logic [3:0] idx;
    } sel_t;

    function automatic logic [MAX_S-1:0] decode(input logic [ADDR_MAX-1:0] addr,
                                                input int                  n_s);
        logic [ADDR_MAX-1:0] page;
        logic [MAX_S-1:0]    sel;
        sel  = '0;
        page = addr >> PAGE_LSB;
        for (int j = 0; j < MAX_S; j++) begin
            if (j < n_s && page == ADDR_MAX'(j + 1)) sel[j] = 1'b1;
        end
        return sel;
    endfunction

    function automatic logic [3:0] onehot2idx(input logic [OH_W-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < OH_W; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Registered round-robin arbiter: one-hot grant, held until the owner releases,
// zero-bubble handover to the next requester after the previous owner.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int N_M = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N_M-1:0] req_i,
    input  logic           rel_i,
    output logic [N_M-1:0] grant_o
);

    localparam int IW = $clog2(N_M);

    state_e         state_q, state_d;
    logic [N_M-1:0] grant_q, grant_d;
    logic [IW-1:0]  last_q, last_d;
    logic [IW-1:0]  owner;
    logic [N_M-1:0] others;

    function automatic logic [N_M-1:0] rr_pick(input logic [N_M-1:0] req,
                                               input logic [IW-1:0]  base);
        logic [N_M-1:0] gnt;
        logic           found;
        logic [IW-1:0]  idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_M; k++) begin
            idx = IW'((int'(base) + k) % N_M);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

    assign owner   = IW'(onehot2idx(OH_W'(grant_q)));
    assign others  = req_i & ~grant_q;
    assign grant_o = grant_q;

    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    grant_d = rr_pick(req_i, last_q);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (rel_i) begin
                    last_d  = owner;
                    grant_d = rr_pick(others, owner);
                    if (!(|others)) state_d = IDLE;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(N_M - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/bus_mm_rr.sv
// Shared bus: N_M masters, N_S slaves, registered round-robin ownership, 1-cycle read return.
// Define BUS_DECERR_EN to add the registered m_err decode-error pulse.
module bus_mm_rr
    import bus_pkg::*;
#(
    parameter int N_M = 2,
    parameter int N_S = 2,
    parameter int AW  = 16,
    parameter int DW  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_M-1:0]    m_req,
    input  logic [N_M-1:0]    m_wr,
    input  logic [N_M*AW-1:0] m_addr,
    input  logic [N_M*DW-1:0] m_dout,
    output logic [N_M-1:0]    m_grant,
    output logic [DW-1:0]     m_din,
    input  logic [N_S*DW-1:0] s_dout,
    output logic [N_S-1:0]    s_sel,
    output logic [AW-1:0]     s_addr,
    output logic              s_wr,
    output logic [DW-1:0]     s_din
`ifdef BUS_DECERR_EN
    ,
    output logic              m_err
`endif
);

    logic           has_owner;
    logic           own_wr;
    logic [AW-1:0]  own_addr;
    logic [DW-1:0]  own_dout;
    logic [N_S-1:0] sel_dec;
    logic           mapped;
    sel_t           sel_q, sel_d;

    bus_rr_arbiter #(.N_M(N_M)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   (m_req),
        .rel_i   (has_owner && !(|(m_req & m_grant))),
        .grant_o (m_grant)
    );

    assign has_owner = |m_grant;

    // AND-OR owner mux; with no grant every field is zero, so page 0 decodes to no slave.
    always_comb begin
        own_wr   = 1'b0;
        own_addr = '0;
        own_dout = '0;
        for (int i = 0; i < N_M; i++) begin
            if (m_grant[i]) begin
                own_wr   = m_wr[i];
                own_addr = m_addr[i*AW +: AW];
                own_dout = m_dout[i*DW +: DW];
            end
        end
    end

    assign sel_dec = N_S'(decode(ADDR_MAX'(own_addr), N_S));
    assign mapped  = |sel_dec;

    assign s_sel  = sel_dec;
    assign s_wr   = has_owner && mapped && own_wr;
    assign s_addr = own_addr;
    assign s_din  = own_dout;

    always_comb begin
        sel_d.vld = has_owner && mapped && !own_wr;
        sel_d.idx = onehot2idx(OH_W'(sel_dec));
    end

    always_comb begin
        m_din = '0;
        for (int j = 0; j < N_S; j++) begin
            if (sel_q.vld && sel_q.idx == 4'(j)) m_din = s_dout[j*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sel_q <= '0;
        else       sel_q <= sel_d;
    end

`ifdef BUS_DECERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= has_owner && !mapped;
    end

    assign m_err = err_q;
`endif

endmodule
